// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes and
// datapath select values. Build option: MULTICYCLE_JUMP_EN adds the JUMP state.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StFetch    = 4'd1,
    StDecode   = 4'd2,
    StMemAddr  = 4'd3,
    StMemRead  = 4'd4,
    StMemWb    = 4'd5,
    StMemWrite = 4'd6,
    StExec     = 4'd7,
    StRWb      = 4'd8,
    StBranch   = 4'd9,
    StAddiEx   = 4'd10,
    StAddiWb   = 4'd11
`ifdef MULTICYCLE_JUMP_EN
    , StJump   = 4'd12
`endif
  } state_e;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  typedef enum logic [1:0] {
    SrcBReg   = 2'b00,
    SrcBFour  = 2'b01,
    SrcBImm   = 2'b10,
    SrcBImmS2 = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    AluAdd   = 2'b00,
    AluSub   = 2'b01,
    AluFunct = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    PcAlu    = 2'b00,
    PcAluOut = 2'b01,
    PcJump   = 2'b10
  } pc_src_e;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory bundle. The controller uses the master
// modport; the datapath (or a bench) uses the slave modport.
interface mc_ctrl_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en;
  logic       ir_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic [3:0] state;
  logic       retire;
  logic       illegal_op;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_en, ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
    output alu_src_a, alu_src_b, alu_op, pc_src, state, retire, illegal_op
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_en, ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
    input  alu_src_a, alu_src_b, alu_op, pc_src, state, retire, illegal_op
  );
endinterface

// File: rtl/multicycle_control_mem_wait_timer.sv
// Memory wait timer: produces rdy either straight from mem_ready (handshake
// mode, FIXED_MEM_LAT=0) or after a fixed number of cycles in a wait state.
module mem_wait_timer #(
  parameter int unsigned FIXED_MEM_LAT = 0,
  parameter int unsigned LAT_W         = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,       // staying in the same wait state next cycle
  input  logic mem_ready,
  output logic rdy
);

  logic [LAT_W-1:0] cnt_q, cnt_d;

  if (FIXED_MEM_LAT >= (1 << LAT_W)) begin : g_bad_cfg
    $error("FIXED_MEM_LAT must be less than 2**LAT_W");
  end

  // Count cycles spent in the current wait state; any state change restarts at zero.
  always_comb begin
    cnt_d = hold ? cnt_q + 1'b1 : '0;
  end

  // Counter register, cleared asynchronously with the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  if (FIXED_MEM_LAT == 0) begin : g_handshake
    assign rdy = mem_ready;
  end else begin : g_fixed
    localparam logic [LAT_W-1:0] LastCnt = LAT_W'(FIXED_MEM_LAT - 1);
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign rdy = (cnt_q == LastCnt);
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style controller FSM. Outputs are Moore-decoded from the
// state except pc_en, ir_write and retire, which also follow rdy or zero.
// Build option: define MULTICYCLE_JUMP_EN to support the j instruction.
module multicycle_control #(
  parameter int unsigned FIXED_MEM_LAT = 0,
  parameter int unsigned LAT_W         = 4
) (
  input  logic       clk,
  input  logic       rst,
  mc_ctrl_if.master  bus
);
  import mc_ctrl_pkg::*;

  state_e state_q, state_d;
  logic   rdy;
  logic   hold;

  assign hold = (state_d == state_q);

  mem_wait_timer #(
    .FIXED_MEM_LAT(FIXED_MEM_LAT),
    .LAT_W        (LAT_W)
  ) u_wait (
    .clk      (clk),
    .rst      (rst),
    .hold     (hold),
    .mem_ready(bus.mem_ready),
    .rdy      (rdy)
  );

  // State register; reset parks in IDLE so every output drops immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  assign bus.state = state_q;

  // Next-state and output decode.
  always_comb begin
    state_d        = state_q;
    bus.pc_en      = 1'b0;
    bus.ir_write   = 1'b0;
    bus.iord       = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = SrcBReg;
    bus.alu_op     = AluAdd;
    bus.pc_src     = PcAlu;
    bus.retire     = 1'b0;
    bus.illegal_op = 1'b0;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = SrcBFour;
        bus.pc_en     = rdy;
        bus.ir_write  = rdy;
        if (rdy) state_d = StDecode;
      end
      StDecode: begin
        bus.alu_src_b = SrcBImmS2;
        case (bus.opcode)
          OpRType:     state_d = StExec;
          OpLw, OpSw:  state_d = StMemAddr;
          OpBeq:       state_d = StBranch;
          OpAddi:      state_d = StAddiEx;
`ifdef MULTICYCLE_JUMP_EN
          OpJ:         state_d = StJump;
`endif
          default: begin
            bus.illegal_op = 1'b1;
            state_d        = StFetch;
          end
        endcase
      end
      StMemAddr: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SrcBImm;
        state_d       = (bus.opcode == OpLw) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
        if (rdy) state_d = StMemWb;
      end
      StMemWb: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.retire     = 1'b1;
        state_d        = StFetch;
      end
      StMemWrite: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
        bus.retire    = rdy;
        if (rdy) state_d = StFetch;
      end
      StExec: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = AluFunct;
        state_d       = StRWb;
      end
      StRWb: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
        bus.retire    = 1'b1;
        state_d       = StFetch;
      end
      StBranch: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = AluSub;
        bus.pc_src    = PcAluOut;
        bus.pc_en     = bus.zero;
        bus.retire    = 1'b1;
        state_d       = StFetch;
      end
      StAddiEx: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SrcBImm;
        state_d       = StAddiWb;
      end
      StAddiWb: begin
        bus.reg_write = 1'b1;
        bus.retire    = 1'b1;
        state_d       = StFetch;
      end
`ifdef MULTICYCLE_JUMP_EN
      StJump: begin
        bus.pc_src = PcJump;
        bus.pc_en  = 1'b1;
        bus.retire = 1'b1;
        state_d    = StFetch;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: two instances (handshake mode and 3-cycle fixed
// latency) share the inputs; one is checked at a time. The stimulus walks an
// instruction-level model (phases per opcode, wait cycles chosen by the bench)
// and queues the expected output word per cycle; a monitor pops and compares.
module tb_multicycle_control;
  import mc_ctrl_pkg::*;

  localparam int unsigned FixedLat = 3;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_en, ir_write, iord, mem_read, mem_write;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] src_b, aop, pc_src;
    logic       retire, illegal;
  } ctrl_t;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mode;   // 0: check handshake instance, 1: check fixed-latency instance

  int total = 0;
  int bad   = 0;
  ctrl_t exp_q[$];

  mc_ctrl_if if0 ();
  mc_ctrl_if if1 ();

  assign if0.opcode = opcode;
  assign if0.zero = zero;
  assign if0.mem_ready = mem_ready;
  assign if1.opcode = opcode;
  assign if1.zero = zero;
  assign if1.mem_ready = mem_ready;

  multicycle_control #(.FIXED_MEM_LAT(0), .LAT_W(4)) dut0 (
    .clk(clk), .rst(rst), .bus(if0.master)
  );
  multicycle_control #(.FIXED_MEM_LAT(FixedLat), .LAT_W(4)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.master)
  );

  ctrl_t act0, act1, act;
  assign act0 = {if0.state, if0.pc_en, if0.ir_write, if0.iord, if0.mem_read, if0.mem_write,
                 if0.reg_write, if0.reg_dst, if0.mem_to_reg, if0.alu_src_a, if0.alu_src_b,
                 if0.alu_op, if0.pc_src, if0.retire, if0.illegal_op};
  assign act1 = {if1.state, if1.pc_en, if1.ir_write, if1.iord, if1.mem_read, if1.mem_write,
                 if1.reg_write, if1.reg_dst, if1.mem_to_reg, if1.alu_src_a, if1.alu_src_b,
                 if1.alu_op, if1.pc_src, if1.retire, if1.illegal_op};
  assign act = mode ? act1 : act0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input ctrl_t a, input ctrl_t e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s t=%0t mode=%0d: got %h (state %0d) expected %h (state %0d)",
               name, $time, mode, a, a.st, e, e.st);
    end
  endtask

  // Monitor: compare the DUT against the oldest queued expectation each cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) check("cycle", act, exp_q.pop_front());
    end
  end

  task automatic push_cycle(input ctrl_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Non-wait cycle: mem_ready is noise here and must be ignored.
  task automatic step(input ctrl_t e);
    mem_ready = 1'($urandom);
    push_cycle(e);
  endtask

  // Wait phase: n stall cycles then the rdy cycle. forced < 0 picks randomly.
  task automatic wait_phase(input ctrl_t e, input ctrl_t er, input int forced);
    int n;
    if (mode) n = FixedLat - 1;
    else if (forced >= 0) n = forced;
    else n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin
      mem_ready = mode ? 1'($urandom) : 1'b0;
      push_cycle(e);
    end
    mem_ready = mode ? 1'($urandom) : 1'b1;
    push_cycle(er);
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    if (op == OpRType || op == OpLw || op == OpSw || op == OpBeq || op == OpAddi) return 1'b1;
`ifdef MULTICYCLE_JUMP_EN
    if (op == OpJ) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Fetch, decode, and (for lw/sw) address phase; common to every instruction.
  task automatic front_end(input logic [5:0] op, input logic z, input int fw_fetch);
    ctrl_t e, er;
    opcode = op;
    zero   = z;
    e = '0; e.st = 4'd1; e.mem_read = 1'b1; e.src_b = 2'b01;
    er = e; er.pc_en = 1'b1; er.ir_write = 1'b1;
    wait_phase(e, er, fw_fetch);
    e = '0; e.st = 4'd2; e.src_b = 2'b11; e.illegal = !is_legal(op);
    step(e);
    if (op == OpLw || op == OpSw) begin
      e = '0; e.st = 4'd3; e.alu_src_a = 1'b1; e.src_b = 2'b10;
      step(e);
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic z, input int fw_fetch,
                           input int fw_mem);
    ctrl_t e, er;
    front_end(op, z, fw_fetch);
    if (!is_legal(op)) return;
    e = '0;
    case (op)
      OpRType: begin
        e.st = 4'd7; e.alu_src_a = 1'b1; e.aop = 2'b10; step(e);
        e = '0; e.st = 4'd8; e.reg_write = 1'b1; e.reg_dst = 1'b1; e.retire = 1'b1; step(e);
      end
      OpLw: begin
        e.st = 4'd4; e.mem_read = 1'b1; e.iord = 1'b1;
        wait_phase(e, e, fw_mem);
        e = '0; e.st = 4'd5; e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.retire = 1'b1; step(e);
      end
      OpSw: begin
        e.st = 4'd6; e.mem_write = 1'b1; e.iord = 1'b1;
        er = e; er.retire = 1'b1;
        wait_phase(e, er, fw_mem);
      end
      OpBeq: begin
        e.st = 4'd9; e.alu_src_a = 1'b1; e.aop = 2'b01; e.pc_src = 2'b01;
        e.pc_en = z; e.retire = 1'b1; step(e);
      end
      OpAddi: begin
        e.st = 4'd10; e.alu_src_a = 1'b1; e.src_b = 2'b10; step(e);
        e = '0; e.st = 4'd11; e.reg_write = 1'b1; e.retire = 1'b1; step(e);
      end
      default: begin
        e.st = 4'd12; e.pc_src = 2'b10; e.pc_en = 1'b1; e.retire = 1'b1; step(e);
      end
    endcase
  endtask

  // Async reset from mid-cycle: outputs must clear before any clock edge.
  task automatic async_reset();
    rst = 1'b1;
    #1;
    check("async_reset", act, ctrl_t'(0));
    @(posedge clk);
    #1;
    push_cycle(ctrl_t'(0));
    rst = 1'b0;
    push_cycle(ctrl_t'(0));
  endtask

  task automatic random_instrs(input int n);
    logic [5:0] op_tab [0:8];
    op_tab = '{OpRType, OpLw, OpSw, OpBeq, OpBeq, OpAddi, OpJ, 6'h3f, 6'h01};
    for (int i = 0; i < n; i++)
      run_instr(op_tab[$urandom_range(0, 8)], 1'($urandom), -1, -1);
  endtask

  initial begin
    ctrl_t e;
    rst = 1'b1; mode = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    push_cycle(ctrl_t'(0));
    rst = 1'b0;
    push_cycle(ctrl_t'(0));

    // Directed handshake-mode cases.
    run_instr(OpRType, 1'b0, 0, 0);
    run_instr(OpLw, 1'b0, 0, 3);
    run_instr(OpBeq, 1'b0, 0, 0);
    run_instr(OpBeq, 1'b1, 0, 0);
    run_instr(OpJ, 1'b0, 0, 0);
    run_instr(OpAddi, 1'b1, 2, 0);
    run_instr(OpSw, 1'b0, 1, 2);
    random_instrs(40);

    // Reset while stalled in MEM_WRITE.
    front_end(OpSw, 1'b0, 0);
    mem_ready = 1'b0;
    e = '0; e.st = 4'd6; e.mem_write = 1'b1; e.iord = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    #2;
    async_reset();
    run_instr(OpRType, 1'b0, 0, 0);

    // Fixed-latency instance.
    mode = 1'b1;
    async_reset();
    run_instr(OpSw, 1'b0, -1, -1);
    run_instr(OpLw, 1'b1, -1, -1);
    random_instrs(30);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter FIXED_MEM_LAT, default 0, SHALL select memory wait mode: 0 = wait on mem_ready handshake; N in 1..15 = fixed N-cycle access, with mem_ready ignored.
REQ-002 Parameter LAT_W, default 4, SHALL set the wait-counter width; FIXED_MEM_LAT SHALL be less than 2**LAT_W.
REQ-003 The block SHALL have one clock, clk, and an asynchronous, active-high reset, rst; ports are listed below with clock and reset first.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 opcode  input  6  instruction[31:26] from external IR; stable from DECODE to end of instruction.
REQ-007 zero  input  1  ALU zero flag.
REQ-008 mem_ready  input  1  memory access complete this cycle.
REQ-009 pc_en, ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a  output  1 each  datapath strobes and selects.
REQ-010 alu_src_b  output  2  encodings: 00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2.
REQ-011 alu_op  output  2  00 = add, 01 = sub, 10 = funct-decoded.
REQ-012 pc_src  output  2  00 = ALU result, 01 = ALUOut register, 10 = jump target.
REQ-013 state  output  4  current state encoding, for debug.
REQ-014 retire  output  1  one-cycle pulse in the final cycle of every completed instruction.
REQ-015 illegal_op  output  1  one-cycle pulse in DECODE when the opcode is unsupported.

Function
REQ-016 States and encodings SHALL be: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXEC=7, R_WB=8, BRANCH=9, ADDI_EX=10, ADDI_WB=11, JUMP=12.
REQ-017 Outputs SHALL be Moore-decoded from state, except pc_en, ir_write and retire, which also depend on rdy or zero; any output not listed for a state SHALL be 0.
REQ-018 rdy SHALL be mem_ready when FIXED_MEM_LAT=0; otherwise rdy SHALL be 1 when the wait counter equals FIXED_MEM_LAT-1.
REQ-019 The wait counter SHALL clear on entry to FETCH, MEM_READ and MEM_WRITE, and SHALL increment each cycle spent in those states.
REQ-020 IDLE SHALL go to FETCH unconditionally; the first fetch therefore begins one cycle after rst deasserts.
REQ-021 FETCH SHALL drive mem_read=1, iord=0, alu_src_b=01, alu_op=00 and pc_src=00, with ir_write=pc_en=rdy; it SHALL stay in FETCH while rdy=0 and go to DECODE when rdy=1.
REQ-022 DECODE SHALL drive alu_src_b=11 and alu_op=00, and SHALL branch on opcode as follows.
- 000000 -> EXEC
- 100011 or 101011 -> MEM_ADDR
- 000100 -> BRANCH
- 001000 -> ADDI_EX
- 000010 -> JUMP (only when JUMP_EN is defined)
- any other opcode -> FETCH, with illegal_op=1 and retire=0
REQ-023 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10 and alu_op=00, then go to MEM_READ for lw and MEM_WRITE for sw.
REQ-024 MEM_READ SHALL drive mem_read=1 and iord=1, holding until rdy=1, then go to MEM_WB.
REQ-025 MEM_WB SHALL drive reg_write=1, mem_to_reg=1, reg_dst=0 and retire=1, then go to FETCH.
REQ-026 MEM_WRITE SHALL drive mem_write=1 and iord=1, holding until rdy=1, and SHALL assert retire=1 in the rdy cycle before going to FETCH.
REQ-027 EXEC SHALL drive alu_src_a=1, alu_src_b=00 and alu_op=10, then go to R_WB; R_WB SHALL drive reg_write=1, reg_dst=1 and retire=1, then go to FETCH.
REQ-028 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero and retire=1, then go to FETCH.
REQ-029 ADDI_EX SHALL drive alu_src_a=1, alu_src_b=10 and alu_op=00, then go to ADDI_WB; ADDI_WB SHALL drive reg_write=1, reg_dst=0 and retire=1, then go to FETCH.
REQ-030 JUMP SHALL drive pc_src=10, pc_en=1 and retire=1, then go to FETCH.
REQ-031 Zero-wait latencies (rdy=1 on first cycle) SHALL be: R-type 4 cycles, lw 5, sw 4, beq 3, addi 4, j 3; each wait cycle adds one.

Reset
REQ-032 rst=1 SHALL force state=IDLE and counter=0 asynchronously, so all outputs are 0 immediately, including mid-access (mem_write drops in the same cycle).
REQ-033 No instruction SHALL resume after reset; execution SHALL restart at FETCH.

Configuration
REQ-034 Macro MULTICYCLE_JUMP_EN defined: opcode 000010 SHALL enter JUMP.
REQ-035 Macro undefined: the JUMP state SHALL be absent, and opcode 000010 SHALL be treated as illegal (illegal_op pulse, then FETCH).

Structure
REQ-036 The shared package mc_ctrl_pkg SHALL hold the state encodings, opcode constants, and alu_src_b, alu_op and pc_src encodings.
REQ-037 The wait counter and rdy generation SHALL be a sub-module, mem_wait_timer, parameterised by FIXED_MEM_LAT and LAT_W.

Verification
REQ-038 Scenario: FIXED_MEM_LAT=0, mem_ready=1, opcode=000000 -> states 1,2,7,8,1; retire high in the R_WB cycle only; reg_dst=1 there.
REQ-039 Scenario: FIXED_MEM_LAT=0, lw with mem_ready low for 3 cycles in MEM_READ -> MEM_READ held 4 cycles; then MEM_WB with mem_to_reg=1; total 8 cycles.
REQ-040 Scenario: FIXED_MEM_LAT=3, mem_ready tied 0, opcode=101011 -> FETCH 3 cycles, ir_write only on the 3rd; MEM_WRITE 3 cycles; retire on the last.
REQ-041 Scenario: beq with zero=0, then with zero=1 -> pc_en=0 in BRANCH, then pc_en=1 with pc_src=01 in BRANCH.
REQ-042 Scenario: opcode=000010 -> with MULTICYCLE_JUMP_EN, states 1,2,12 with pc_src=10; without it, illegal_op pulse in DECODE, then FETCH with no retire.
REQ-043 Scenario: rst asserted mid-MEM_WRITE -> mem_write=0 and state=0 without waiting for a clock edge; FETCH follows one cycle after release.
